// File: rtl/seg_pipe_adder.sv
// Pipelined segmented adder/subtractor: SEG bits are summed per stage with the carry
// registered between stages, and a single advance signal stalls the whole pipeline.
module seg_pipe_adder #(
    parameter int WIDTH = 24,
    parameter int SEG   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSEG = WIDTH / SEG;

    // Handshake: a transfer happens on an edge where valid && ready are both high.
    // The pipeline advances when the output register is empty or being consumed,
    // so in_ready depends only on out_valid and out_ready.
    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_eff    = sub ? ~b : b;
    assign c_eff    = sub ? 1'b1 : cin;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int SW = WIDTH - k * SEG;  // operand bits not yet added
        localparam int RW = (k + 1) * SEG;    // result bits produced so far

        logic [SW-1:0]  src_a;
        logic [SW-1:0]  src_b;
        logic           src_v;
        logic           src_c;
        logic           src_sa;
        logic           src_sb;
        logic           load;
        logic [SEG:0]   slice_sum;
        logic [RW-1:0]  nxt_res;

        logic           r_v;
        logic           r_c;
        logic           r_sa;
        logic           r_sb;
        logic [RW-1:0]  r_res;

        if (k == 0) begin : g_head
            assign src_v   = in_valid;
            assign src_a   = a;
            assign src_b   = b_eff;
            assign src_c   = c_eff;
            assign src_sa  = a[WIDTH-1];
            assign src_sb  = b_eff[WIDTH-1];
            assign load    = in_valid;
            assign nxt_res = slice_sum[SEG-1:0];
        end else begin : g_body
            // Bubbles carry their data along too, so downstream stages always load.
            assign src_v   = g_stage[k-1].r_v;
            assign src_a   = g_stage[k-1].g_ops.r_a;
            assign src_b   = g_stage[k-1].g_ops.r_b;
            assign src_c   = g_stage[k-1].r_c;
            assign src_sa  = g_stage[k-1].r_sa;
            assign src_sb  = g_stage[k-1].r_sb;
            assign load    = 1'b1;
            assign nxt_res = {slice_sum[SEG-1:0], g_stage[k-1].r_res};
        end

        assign slice_sum = {1'b0, src_a[SEG-1:0]} + {1'b0, src_b[SEG-1:0]}
                         + {{SEG{1'b0}}, src_c};

        always_ff @(posedge clk) begin
            if (rst) begin
                r_v   <= 1'b0;
                r_c   <= 1'b0;
                r_sa  <= 1'b0;
                r_sb  <= 1'b0;
                r_res <= '0;
            end else if (adv) begin
                r_v <= src_v;
                if (load) begin
                    r_c   <= slice_sum[SEG];
                    r_sa  <= src_sa;
                    r_sb  <= src_sb;
                    r_res <= nxt_res;
                end
            end
        end

        if (SW > SEG) begin : g_ops
            logic [SW-SEG-1:0] r_a;
            logic [SW-SEG-1:0] r_b;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (adv && load) begin
                    r_a <= src_a[SW-1:SEG];
                    r_b <= src_b[SW-1:SEG];
                end
            end
        end
    end

    assign out_valid = g_stage[NSEG-1].r_v;
    assign sum       = g_stage[NSEG-1].r_res;
    assign cout      = g_stage[NSEG-1].r_c;
    assign ovf       = (g_stage[NSEG-1].r_sa == g_stage[NSEG-1].r_sb)
                    && (g_stage[NSEG-1].r_res[WIDTH-1] != g_stage[NSEG-1].r_sa);

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Self-checking bench for seg_pipe_adder (WIDTH=24, SEG=12, latency 2): directed
// corner cases, back-pressure, mid-flight reset and random traffic against a reference model.
module tb_seg_pipe_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] a;
    logic [23:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] sum;
    logic        cout;
    logic        ovf;

    int errors = 0;
    int checks = 0;
    logic [25:0] exp_q[$];

    seg_pipe_adder #(.WIDTH(24), .SEG(12)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Arithmetic reference: returns {ovf, cout, sum} from plain integer math.
    function automatic logic [25:0] model(input logic [23:0] ma, input logic [23:0] mb,
                                          input logic mcin, input logic msub);
        longint ua, ub, full, sa, sb, sr;
        logic   c, v;
        ua   = longint'(ma);
        ub   = longint'(mb);
        full = msub ? (ua - ub + 16777216) : (ua + ub + longint'(mcin));
        sa   = (ua >= 8388608) ? ua - 16777216 : ua;
        sb   = (ub >= 8388608) ? ub - 16777216 : ub;
        sr   = msub ? (sa - sb) : (sa + sb + longint'(mcin));
        v    = (sr > 8388607) || (sr < -8388608);
        c    = (full >= 16777216);
        return {v, c, full[23:0]};
    endfunction

    // Scoreboard: accepted inputs are queued, consumed outputs are compared in order.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_spurious: got {ovf,cout,sum}=%h, expected no result",
                             {ovf, cout, sum});
                end else begin
                    logic [25:0] exp;
                    exp = exp_q.pop_front();
                    if ({ovf, cout, sum} !== exp) begin
                        errors++;
                        $display("FAIL scoreboard_result: got {ovf,cout,sum}=%h, expected %h",
                                 {ovf, cout, sum}, exp);
                    end
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(a, b, cin, sub));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid);
        end
        checks++;
        if ({ovf, cout, sum} !== 26'h0) begin
            errors++; $display("FAIL reset_outputs: got {ovf,cout,sum}=%h, expected 0", {ovf, cout, sum});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [23:0] ta [6] = '{24'hFFFFFF, 24'h000FFF, 24'h000FFF, 24'h000005, 24'h7FFFFF, 24'h800000};
        logic [23:0] tb [6] = '{24'h000001, 24'h000000, 24'h000001, 24'h000007, 24'h000001, 24'h000001};
        logic        tc [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        ts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [25:0] te [6] = '{{2'b01, 24'h000000}, {2'b00, 24'h001000}, {2'b00, 24'h001000},
                                {2'b00, 24'hFFFFFE}, {2'b10, 24'h800000}, {2'b11, 24'h7FFFFF}};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            int n;
            in_valid = 1'b1;
            a = ta[i]; b = tb[i]; cin = tc[i]; sub = ts[i];
            step();
            in_valid = 1'b0;
            n = 1;
            while (!out_valid && n < 8) begin
                step();
                n++;
            end
            checks++;
            if (n !== 2) begin
                errors++; $display("FAIL directed_latency_%0d: got %0d cycles, expected 2", i, n);
            end
            checks++;
            if ({ovf, cout, sum} !== te[i]) begin
                errors++;
                $display("FAIL directed_result_%0d: got {ovf,cout,sum}=%h, expected %h", i, {ovf, cout, sum}, te[i]);
            end
            step();
        end
    endtask

    task automatic test_back_pressure();
        int         sent = 0;
        int         got = 0;
        int         stall_left = 0;
        int         last_cyc = 0;
        bit         started = 0;
        logic [26:0] snap = '0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            in_valid = (sent < 4);
            a = 24'(sent); b = 24'h000100; cin = 1'b0; sub = 1'b0;
            if (!started && out_valid) begin
                started = 1;
                stall_left = 3;
                snap = {out_valid, ovf, cout, sum};
            end
            out_ready = (stall_left == 0);
            @(negedge clk);
            if (stall_left > 0) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++; $display("FAIL stall_in_ready: got %b, expected 0", in_ready);
                end
                checks++;
                if ({out_valid, ovf, cout, sum} !== snap) begin
                    errors++;
                    $display("FAIL stall_stable: got %h, expected %h", {out_valid, ovf, cout, sum}, snap);
                end
                stall_left--;
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                if (got > 0) begin
                    checks++;
                    if (cyc - last_cyc !== 1) begin
                        errors++; $display("FAIL bp_throughput: got gap %0d, expected 1", cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                got++;
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got !== 4) begin
            errors++; $display("FAIL bp_count: got %0d results, expected 4", got);
        end
    endtask

    task automatic test_reset_midflight();
        int n;
        out_ready = 1'b1;
        in_valid = 1'b1; a = 24'h111111; b = 24'h000222; cin = 1'b0; sub = 1'b0;
        step();
        a = 24'h123456; b = 24'h654321;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_out_valid: got %b, expected 0", out_valid);
        end
        checks++;
        if ({ovf, cout, sum} !== 26'h0) begin
            errors++; $display("FAIL midreset_outputs: got {ovf,cout,sum}=%h, expected 0", {ovf, cout, sum});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_in_ready: got %b, expected 1", in_ready);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL midreset_stale_%0d: got out_valid=%b, expected 0", i, out_valid);
            end
        end
        in_valid = 1'b1; a = 24'h000ABC; b = 24'h000123; cin = 1'b1; sub = 1'b0;
        step();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 8) begin
            step();
            n++;
        end
        checks++;
        if (n !== 2) begin
            errors++; $display("FAIL midreset_latency: got %0d cycles, expected 2", n);
        end
        checks++;
        if ({ovf, cout, sum} !== {2'b00, 24'h000BE0}) begin
            errors++; $display("FAIL midreset_result: got {ovf,cout,sum}=%h, expected %h", {ovf, cout, sum}, {2'b00, 24'h000BE0});
        end
        step();
    endtask

    function automatic logic [23:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 24'h000000;
            1: return 24'hFFFFFF;
            2: return 24'h7FFFFF;
            3: return 24'h800000;
            4: return 24'h000FFF;
            default: return 24'($urandom);
        endcase
    endfunction

    task automatic test_random();
        int n;
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = pick_operand(); b = pick_operand();
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL random_in_ready_%0d: got %b, expected %b", i, in_ready, !out_valid || out_ready);
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL random_drain: got %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        test_reset();
        test_directed();
        test_back_pressure();
        step();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
